// File: rtl/instr_seq.sv
// rtl/instr_seq.sv - fetch/decode sequencer feeding the microcode ROM stage
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add the step input.
module instr_seq #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            pmem_req,
    output logic [PC_W-1:0] pmem_addr,
    input  logic            pmem_ack,
    input  logic [7:0]      pmem_data,
    output logic [7:0]      instr,
    output logic [1:0]      en,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_OPFETCH, S_HALT
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic [PC_W-1:0] jmp_target;
    logic            start;
    logic            cont;
    logic            is_ctrl;
    logic            is_halt;
    logic            is_jmp;
    logic [1:0]      dec_en;

    // pmem_addr doubles as the program counter.
    generate
        if (PC_W > 8) begin : g_wide
            assign jmp_target = {{(PC_W-8){1'b0}}, pmem_data};
        end else begin : g_narrow
            assign jmp_target = pmem_data[PC_W-1:0];
        end
    endgenerate

`ifdef SEQ_SINGLE_STEP_EN
    assign start = run & step;
    assign cont  = 1'b0;
`else
    assign start = run;
    assign cont  = run;
`endif

    assign is_ctrl = ~instr[7] & instr[3];
    assign is_halt = is_ctrl & (instr[2:0] == 3'b111);
    assign is_jmp  = is_ctrl & (instr[2:0] == 3'b001);
    assign dec_en  = instr[7] ? 2'b11 : (instr[3] ? 2'b10 : 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pmem_addr <= RESET_PC;
            pmem_req  <= 1'b0;
            instr     <= 8'h00;
            en        <= 2'b00;
            busy      <= 1'b0;
            halted    <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pmem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (pmem_ack) begin
                        instr     <= pmem_data;
                        pmem_addr <= pmem_addr + 1'b1;
                        pmem_req  <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else if (is_jmp) begin
                        state    <= S_OPFETCH;
                        pmem_req <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                        en    <= dec_en;
                        cnt   <= CNT_INIT;
                    end
                end
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        en <= 2'b00;
                        if (cont) begin
                            state    <= S_FETCH;
                            pmem_req <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_OPFETCH: begin
                    // A continuing JMP keeps req asserted straight into the next fetch.
                    if (pmem_ack) begin
                        pmem_addr <= jmp_target;
                        if (cont) begin
                            state <= S_FETCH;
                        end else begin
                            state    <= S_IDLE;
                            pmem_req <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
